// File: rtl/control_tablero.sv
// Move controller for the tic-tac-toe board: validates a requested cell, writes the
// current player's symbol, detects win/draw and alternates turns.
module control_tablero #(
    parameter logic [5:0] CODE_X = 6'b111000,
    parameter logic [5:0] CODE_O = 6'b000111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nuevo_juego,
    input  logic       mover,
    input  logic [3:0] casilla,
    output logic [5:0] celda0,
    output logic [5:0] celda1,
    output logic [5:0] celda2,
    output logic [5:0] celda3,
    output logic [5:0] celda4,
    output logic [5:0] celda5,
    output logic [5:0] celda6,
    output logic [5:0] celda7,
    output logic [5:0] celda8,
    output logic       turno,
    output logic       listo,
    output logic       invalida,
    output logic       fin,
    output logic [1:0] ganador
);

    // state   | meaning
    // S_IDLE  | waiting for a move request
    // S_CHECK | validate latched cell, write symbol or reject
    // S_EVAL  | look for a completed line or a full board
    // S_FIN   | game over, held until board clear
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EVAL, S_FIN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cas_q, cas_d;
    logic [5:0]  celda_q [9];
    logic [5:0]  celda_d [9];
    logic        turno_q, turno_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        inval_q, inval_d;
    logic [1:0]  gan_q, gan_d;

    logic [5:0]  code_cur;
    logic        occupied;
    logic        win;

    function automatic logic line3(input logic [5:0] a, input logic [5:0] b,
                                   input logic [5:0] c, input logic [5:0] code);
        return (a == code) && (b == code) && (c == code);
    endfunction

    assign code_cur = turno_q ? CODE_O : CODE_X;

    always_comb begin
        occupied = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if ((cas_q == i[3:0]) && (celda_q[i] != 6'd0)) occupied = 1'b1;
        end
    end

    always_comb begin
        win = line3(celda_q[0], celda_q[1], celda_q[2], code_cur) |
              line3(celda_q[3], celda_q[4], celda_q[5], code_cur) |
              line3(celda_q[6], celda_q[7], celda_q[8], code_cur) |
              line3(celda_q[0], celda_q[3], celda_q[6], code_cur) |
              line3(celda_q[1], celda_q[4], celda_q[7], code_cur) |
              line3(celda_q[2], celda_q[5], celda_q[8], code_cur) |
              line3(celda_q[0], celda_q[4], celda_q[8], code_cur) |
              line3(celda_q[2], celda_q[4], celda_q[6], code_cur);
    end

    always_comb begin
        state_d = state_q;
        cas_d   = cas_q;
        celda_d = celda_q;
        turno_d = turno_q;
        cnt_d   = cnt_q;
        inval_d = 1'b0;
        gan_d   = gan_q;
        case (state_q)
            S_IDLE: begin
                if (mover) begin
                    cas_d   = casilla;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((cas_q > 4'd8) || occupied) begin
                    inval_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    for (int i = 0; i < 9; i++) begin
                        if (cas_q == i[3:0]) celda_d[i] = code_cur;
                    end
                    cnt_d   = (cnt_q >= 4'd9) ? 4'd9 : cnt_q + 4'd1;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                // A completed line on the ninth move beats the draw.
                if (win) begin
                    gan_d   = turno_q ? 2'b10 : 2'b01;
                    state_d = S_FIN;
                end else if (cnt_q == 4'd9) begin
                    gan_d   = 2'b11;
                    state_d = S_FIN;
                end else begin
                    turno_d = ~turno_q;
                    state_d = S_IDLE;
                end
            end
            S_FIN:   state_d = S_FIN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || nuevo_juego) begin
            state_q <= S_IDLE;
            cas_q   <= 4'd0;
            for (int i = 0; i < 9; i++) celda_q[i] <= 6'd0;
            turno_q <= 1'b0;
            cnt_q   <= 4'd0;
            inval_q <= 1'b0;
            gan_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cas_q   <= cas_d;
            celda_q <= celda_d;
            turno_q <= turno_d;
            cnt_q   <= cnt_d;
            inval_q <= inval_d;
            gan_q   <= gan_d;
        end
    end

    assign celda0   = celda_q[0];
    assign celda1   = celda_q[1];
    assign celda2   = celda_q[2];
    assign celda3   = celda_q[3];
    assign celda4   = celda_q[4];
    assign celda5   = celda_q[5];
    assign celda6   = celda_q[6];
    assign celda7   = celda_q[7];
    assign celda8   = celda_q[8];
    assign turno    = turno_q;
    assign listo    = (state_q == S_IDLE);
    assign invalida = inval_q;
    assign fin      = (state_q == S_FIN);
    assign ganador  = gan_q;

endmodule
